// File: rtl/period_slot_arbiter.sv
// period_slot_arbiter: one-at-a-time round-robin grant of a shared upload resource, paced by
// period ticks so that each requester is served at most once per period, with a grant timeout.
module period_slot_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int CNT_W       = 24
) (
  input  logic               sys_clk_i,
  input  logic               rst_n_i,
  input  logic               period_reset_i,
  input  logic               period_tick_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] done_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic               busy_o,
  output logic [15:0]        frame_cnt_o,
  output logic               timeout_o,
  output logic               overrun_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_START,
    ST_SCAN,
    ST_GRANT,
    ST_WAIT
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic               r_busy;
  logic [15:0]        r_frame_cnt, w_frame_cnt_nxt;
  logic               r_timeout, w_timeout_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic [PTR_W-1:0]   r_ptr, w_ptr_nxt;
  logic [NUM_REQ-1:0] r_served, w_served_nxt;
  logic               r_tick_pend, w_tick_pend_nxt;
  logic [CNT_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;

  logic [NUM_REQ-1:0] w_cand;
  logic [PTR_W-1:0]   w_idx [NUM_REQ];
  logic               w_found;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_gidx;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_done;
  logic               w_tmo;

  assign w_cand      = req_i & ~r_served;
  assign w_done      = |(done_i & r_grant);
  assign w_tmo       = (r_tmo_cnt == TMO_LAST);
  assign w_ptr_after = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gidx + PTR_W'(1);

  // Search order starts at the pointer and wraps, so the last-served requester goes to the back.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx[i] = PTR_W'((int'(r_ptr) + i) % NUM_REQ);
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && w_cand[w_idx[i]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[i];
      end
    end
  end

  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) w_gidx = PTR_W'(i);
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_frame_cnt_nxt = r_frame_cnt;
    w_timeout_nxt   = 1'b0;
    w_overrun_nxt   = 1'b0;
    w_ptr_nxt       = r_ptr;
    w_served_nxt    = r_served;
    w_tick_pend_nxt = r_tick_pend;
    w_tmo_cnt_nxt   = r_tmo_cnt;

    // The time base being held overrides everything, including a live grant.
    if (period_reset_i) begin
      w_state_nxt     = ST_HOLD;
      w_grant_nxt     = '0;
      w_frame_cnt_nxt = '0;
      w_served_nxt    = '0;
      w_tick_pend_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (period_tick_i) w_state_nxt = ST_START;
        end
        ST_HOLD: begin
          w_grant_nxt     = '0;
          w_frame_cnt_nxt = '0;
          w_served_nxt    = '0;
          w_tick_pend_nxt = 1'b0;
          w_state_nxt     = ST_IDLE;
        end
        ST_START: begin
          w_served_nxt    = '0;
          w_tick_pend_nxt = 1'b0;
          w_frame_cnt_nxt = r_frame_cnt + 16'd1;
          w_state_nxt     = ST_SCAN;
        end
        ST_SCAN: begin
          if (period_tick_i) w_tick_pend_nxt = 1'b1;
          if (w_found) begin
            w_grant_nxt   = NUM_REQ'(1) << w_sel;
            w_tmo_cnt_nxt = '0;
            w_state_nxt   = ST_GRANT;
          end else if (r_tick_pend || period_tick_i) begin
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_GRANT: begin
          w_tmo_cnt_nxt = r_tmo_cnt + CNT_W'(1);
          if (period_tick_i) begin
            w_overrun_nxt   = 1'b1;
            w_tick_pend_nxt = 1'b1;
          end
          if (w_done || w_tmo) begin
            w_grant_nxt   = '0;
            w_served_nxt  = r_served | r_grant;
            w_ptr_nxt     = w_ptr_after;
            w_timeout_nxt = w_tmo && !w_done;
            w_state_nxt   = (r_tick_pend || period_tick_i) ? ST_START : ST_SCAN;
          end
        end
        ST_WAIT: begin
          if (period_tick_i) w_state_nxt = ST_START;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_frame_cnt <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
      r_ptr       <= '0;
      r_served    <= '0;
      r_tick_pend <= 1'b0;
      r_tmo_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= |w_grant_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_timeout   <= w_timeout_nxt;
      r_overrun   <= w_overrun_nxt;
      r_ptr       <= w_ptr_nxt;
      r_served    <= w_served_nxt;
      r_tick_pend <= w_tick_pend_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
    end
  end

  assign grant_o     = r_grant;
  assign busy_o      = r_busy;
  assign frame_cnt_o = r_frame_cnt;
  assign timeout_o   = r_timeout;
  assign overrun_o   = r_overrun;

endmodule

// File: tb/tb_period_slot_arbiter.sv
// tb_period_slot_arbiter: directed scenarios for period_slot_arbiter, checked every cycle against
// a timestamp-based behavioural model plus hand-computed literal expectations.
module tb_period_slot_arbiter;

  localparam int NREQ     = 4;
  localparam int TMO      = 100;
  localparam int TICK_PER = 2500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       periodReset = 1'b0;
  logic       tickGen = 1'b0;
  logic       tickMan = 1'b0;
  logic       tick;
  logic [3:0] req = 4'd0;
  logic [3:0] done = 4'd0;
  logic       tickEn = 1'b0;

  logic [3:0]  grant;
  logic        busy;
  logic [15:0] frameCnt;
  logic        timeoutP;
  logic        overrunP;

  int checks = 0;
  int errors = 0;

  assign tick = tickGen | tickMan;

  period_slot_arbiter #(
    .NUM_REQ    (NREQ),
    .TIMEOUT_CYC(TMO),
    .CNT_W      (24)
  ) dut (
    .sys_clk_i     (clk),
    .rst_n_i       (rst_n),
    .period_reset_i(periodReset),
    .period_tick_i (tick),
    .req_i         (req),
    .done_i        (done),
    .grant_o       (grant),
    .busy_o        (busy),
    .frame_cnt_o   (frameCnt),
    .timeout_o     (timeoutP),
    .overrun_o     (overrunP)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal, input logic [3:0] doneVal);
    req  = reqVal;
    done = doneVal;
  endtask

  task automatic waitTick(output bit found);
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (tick) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitGrant(output bit found);
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (grant != 4'd0) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Free-running period tick source; the first tick comes shortly after enabling.
  int tickCnt = TICK_PER - 20;
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (tickEn) begin
        if (tickCnt >= TICK_PER - 1) begin
          tickGen = 1'b1;
          tickCnt = 0;
        end else begin
          tickGen = 1'b0;
          tickCnt++;
        end
      end else begin
        tickGen = 1'b0;
        tickCnt = TICK_PER - 20;
      end
    end
  end

  // Model: tracks the owner, when the grant became visible, and the cycles at which the
  // next period start or next selection is due; outputs follow from these directly.
  int  mCyc = 0;
  int  mStartAt = -1;
  int  mScanAt = -1;
  int  mOwner = -1;
  int  mGrantCyc = 0;
  int  mPtr = 0;
  int  mFrame = 0;
  bit  [3:0] mServed = 4'd0;
  bit  mPend = 1'b0;
  bit  mHold = 1'b0;
  bit  mTmo = 1'b0;
  bit  mOvr = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int  pick;
    int  k;
    int  elapsed;
    bit  isDone;
    bit  isTmo;
    if (!rst_n) begin
      mCyc = 0; mStartAt = -1; mScanAt = -1; mOwner = -1; mPtr = 0; mFrame = 0;
      mServed = 4'd0; mPend = 1'b0; mHold = 1'b0; mTmo = 1'b0; mOvr = 1'b0;
    end else begin
      mTmo = 1'b0;
      mOvr = 1'b0;
      if (periodReset) begin
        mHold = 1'b1; mOwner = -1; mFrame = 0; mServed = 4'd0; mPend = 1'b0;
        mStartAt = -1; mScanAt = -1;
      end else if (mHold) begin
        mHold = 1'b0;
      end else if (mStartAt == mCyc) begin
        mFrame   = (mFrame + 1) % 65536;
        mServed  = 4'd0;
        mPend    = 1'b0;
        mScanAt  = mCyc + 1;
      end else if (mScanAt == mCyc) begin
        pick = -1;
        for (int d = 0; d < NREQ; d++) begin
          k = (mPtr + d) % NREQ;
          if (pick < 0 && req[k] && !mServed[k]) pick = k;
        end
        if (tick) mPend = 1'b1;
        if (pick >= 0) begin
          mOwner    = pick;
          mGrantCyc = mCyc + 1;
        end else if (mPend) begin
          mStartAt = mCyc + 1;
        end
      end else if (mOwner >= 0) begin
        elapsed = mCyc - mGrantCyc + 1;
        isDone  = done[mOwner];
        isTmo   = (elapsed >= TMO);
        if (tick) begin
          mOvr  = 1'b1;
          mPend = 1'b1;
        end
        if (isDone || isTmo) begin
          mTmo           = isTmo && !isDone;
          mServed[mOwner] = 1'b1;
          mPtr           = (mOwner + 1) % NREQ;
          mOwner         = -1;
          if (mPend) mStartAt = mCyc + 1;
          else       mScanAt  = mCyc + 1;
        end
      end else if (tick) begin
        mStartAt = mCyc + 1;
      end
      mCyc++;
    end
  end

  always @(negedge clk) begin
    logic [3:0] expGrant;
    expGrant = (mOwner >= 0) ? (4'b0001 << mOwner) : 4'd0;
    checkOutput("cyc_grant",   32'(grant),    32'(expGrant));
    checkOutput("cyc_busy",    32'(busy),     32'(mOwner >= 0));
    checkOutput("cyc_frame",   32'(frameCnt), 32'(mFrame));
    checkOutput("cyc_timeout", 32'(timeoutP), 32'(mTmo));
    checkOutput("cyc_overrun", 32'(overrunP), 32'(mOvr));
  end

  logic [3:0] rrExp [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  task automatic runRoundRobinPeriod(input int expFrame);
    bit found;
    waitTick(found);
    checkOutput("rr_tick_seen", 32'(found), 32'd1);
    waitCycles(2);
    checkOutput("rr_frame", 32'(frameCnt), 32'(expFrame));
    waitCycles(1);
    checkOutput("rr_first_grant", 32'(grant), 32'b0001);
    for (int k = 0; k < 4; k++) begin
      waitGrant(found);
      checkOutput("rr_grant_seen", 32'(found), 32'd1);
      checkOutput("rr_grant", 32'(grant), 32'(rrExp[k]));
      waitCycles(10);
      applyStimulus(4'b1111, rrExp[k]);
      waitCycles(1);
      applyStimulus(4'b1111, 4'b0000);
    end
  endtask

  initial begin
    bit found;
    int count;
    $display("[TB] start");

    waitCycles(3);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_frame", 32'(frameCnt), 32'd0);
    checkOutput("rst_timeout", 32'(timeoutP), 32'd0);
    rst_n = 1'b1;

    $display("[TB] bring-up hold and round-robin");
    periodReset = 1'b1;
    applyStimulus(4'b1111, 4'b0000);
    waitCycles(TICK_PER);
    checkOutput("hold_grant", 32'(grant), 32'd0);
    checkOutput("hold_frame", 32'(frameCnt), 32'd0);
    periodReset = 1'b0;
    tickEn = 1'b1;
    runRoundRobinPeriod(1);
    runRoundRobinPeriod(2);

    $display("[TB] timeout");
    applyStimulus(4'b0010, 4'b0000);
    waitTick(found);
    checkOutput("tmo_tick_seen", 32'(found), 32'd1);
    waitGrant(found);
    checkOutput("tmo_grant", 32'(grant), 32'b0010);
    count = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (grant !== 4'b0010) break;
      count++;
    end
    checkOutput("tmo_len", 32'(count), 32'd100);
    checkOutput("tmo_pulse", 32'(timeoutP), 32'd1);
    waitCycles(50);
    checkOutput("tmo_no_regrant", 32'(grant), 32'd0);

    $display("[TB] done coincident with timeout");
    applyStimulus(4'b0100, 4'b0000);
    waitTick(found);
    waitGrant(found);
    checkOutput("sim_grant", 32'(grant), 32'b0100);
    waitCycles(5);
    applyStimulus(4'b0100, 4'b0001);
    waitCycles(1);
    applyStimulus(4'b0100, 4'b0000);
    checkOutput("sim_other_done", 32'(grant), 32'b0100);
    waitCycles(14);
    applyStimulus(4'b0000, 4'b0000);
    waitCycles(79);
    applyStimulus(4'b0000, 4'b0100);
    waitCycles(1);
    applyStimulus(4'b0000, 4'b0000);
    checkOutput("sim_grant_off", 32'(grant), 32'd0);
    checkOutput("sim_no_timeout", 32'(timeoutP), 32'd0);

    $display("[TB] overrun");
    applyStimulus(4'b1000, 4'b0000);
    waitTick(found);
    waitGrant(found);
    checkOutput("ovr_grant", 32'(grant), 32'b1000);
    waitCycles(20);
    tickMan = 1'b1;
    waitCycles(1);
    tickMan = 1'b0;
    checkOutput("ovr_pulse1", 32'(overrunP), 32'd1);
    waitCycles(19);
    tickMan = 1'b1;
    waitCycles(1);
    tickMan = 1'b0;
    checkOutput("ovr_pulse2", 32'(overrunP), 32'd1);
    checkOutput("ovr_frame_held", 32'(frameCnt), 32'd5);
    waitCycles(19);
    applyStimulus(4'b1000, 4'b1000);
    waitCycles(1);
    applyStimulus(4'b1000, 4'b0000);
    checkOutput("ovr_grant_off", 32'(grant), 32'd0);
    waitCycles(1);
    checkOutput("ovr_frame_inc", 32'(frameCnt), 32'd6);
    waitCycles(1);
    checkOutput("ovr_regrant", 32'(grant), 32'b1000);
    checkOutput("ovr_busy", 32'(busy), 32'd1);

    $display("[TB] hold and reset mid-grant");
    waitCycles(10);
    periodReset = 1'b1;
    waitCycles(1);
    checkOutput("hold_mid_grant", 32'(grant), 32'd0);
    checkOutput("hold_mid_frame", 32'(frameCnt), 32'd0);
    checkOutput("hold_mid_busy", 32'(busy), 32'd0);
    waitCycles(19);
    periodReset = 1'b0;
    applyStimulus(4'b1111, 4'b0000);
    waitTick(found);
    checkOutput("post_hold_tick", 32'(found), 32'd1);
    waitCycles(3);
    checkOutput("post_hold_grant", 32'(grant), 32'b0001);
    checkOutput("post_hold_frame", 32'(frameCnt), 32'd1);
    waitCycles(5);
    rst_n = 1'b0;
    #1;
    checkOutput("async_grant", 32'(grant), 32'd0);
    checkOutput("async_busy", 32'(busy), 32'd0);
    checkOutput("async_frame", 32'(frameCnt), 32'd0);
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
